// File: rtl/draw_cmd_sender.sv
`default_nettype none
// ============================================================================
// Module   : draw_cmd_sender
// Purpose  : Transmit side of the render command byte link. Accepts one
//            parallel draw command (header + up to 6 operands), emits a
//            STATUS start pulse, then walks each byte out with an RByte/VALID
//            level handshake, and finally waits for FinishRead/FinishWrite.
// Options  : DRAW_CMD_TIMEOUT_EN - builds a watchdog on the Finish wait states.
// Revision : 1.0 - initial release
// ============================================================================
module draw_cmd_sender #(
  parameter int HOLD_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        ACLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [55:0] CMD_DATA,
  output logic        STATUS,
  output logic [7:0]  RByte,
  output logic        VALID,
  input  logic        FinishRead,
  input  logic        FinishWrite,
  output logic        BUSY,
  output logic        ERR,
  output logic        TIMEOUT
);

  localparam logic [2:0] c_S_IDLE      = 3'd0;
  localparam logic [2:0] c_S_START     = 3'd1;
  localparam logic [2:0] c_S_SETUP     = 3'd2;
  localparam logic [2:0] c_S_HIGH      = 3'd3;
  localparam logic [2:0] c_S_LOW       = 3'd4;
  localparam logic [2:0] c_S_WAIT_READ = 3'd5;
  localparam logic [2:0] c_S_WAIT_DONE = 3'd6;

  localparam int c_CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);

  logic [2:0]         r_state;
  logic               r_pending;
  logic [55:0]        r_data;
  logic [2:0]         r_index;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_cmd_ready;
  logic               r_status;
  logic [7:0]         r_rbyte;
  logic               r_valid;
  logic               r_busy;
  logic               r_err;

  logic [7:0] w_hdr;
  logic       w_hdr_ok;
  logic [2:0] w_last_idx;
  logic [2:0] w_sel_idx;
  logic [7:0] w_sel_byte;
  logic       w_wd_fire;

  // Header decode: zero header and length code 3 are rejected; N-1 = 2*len+1
  assign w_hdr      = r_data[7:0];
  assign w_hdr_ok   = (w_hdr != 8'h00) && (w_hdr[1:0] != 2'b11);
  assign w_last_idx = {w_hdr[1:0], 1'b1};

  // The byte loaded into RByte on SETUP entry: byte 0 from START, else the next one
  assign w_sel_idx = (r_state == c_S_START) ? 3'd0 : (r_index + 3'd1);

  // Byte mux over the latched command; index 7 never occurs
  always_comb begin
    w_sel_byte = 8'h00;
    case (w_sel_idx)
      3'd0:    w_sel_byte = r_data[7:0];
      3'd1:    w_sel_byte = r_data[15:8];
      3'd2:    w_sel_byte = r_data[23:16];
      3'd3:    w_sel_byte = r_data[31:24];
      3'd4:    w_sel_byte = r_data[39:32];
      3'd5:    w_sel_byte = r_data[47:40];
      3'd6:    w_sel_byte = r_data[55:48];
      default: w_sel_byte = 8'h00;
    endcase
  end

`ifdef DRAW_CMD_TIMEOUT_EN
  localparam logic [15:0] c_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wd_cnt;
  logic        r_timeout;

  // Watchdog: counts only in the wait states, restarts when moving into each
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      r_wd_cnt <= 16'd0;
    end else if (r_state == c_S_WAIT_READ && FinishRead) begin
      r_wd_cnt <= 16'd0;
    end else if (r_state == c_S_WAIT_READ || r_state == c_S_WAIT_DONE) begin
      if (r_wd_cnt != 16'hFFFF) r_wd_cnt <= r_wd_cnt + 16'd1;
    end else begin
      r_wd_cnt <= 16'd0;
    end
  end

  // Expiry only fires when no Finish condition is present in the same cycle
  assign w_wd_fire = (r_wd_cnt == c_WD_LAST) &&
                     ((r_state == c_S_WAIT_READ && !FinishRead) ||
                      (r_state == c_S_WAIT_DONE && !FinishWrite));

  // One-cycle registered timeout pulse
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) r_timeout <= 1'b0;
    else       r_timeout <= w_wd_fire;
  end

  assign TIMEOUT = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_wd_fire        = 1'b0;
  assign TIMEOUT          = 1'b0;
`endif

  // Main sequencer; every output is registered and set on the transition
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= c_S_IDLE;
      r_pending   <= 1'b0;
      r_data      <= 56'd0;
      r_index     <= 3'd0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_status    <= 1'b0;
      r_rbyte     <= 8'h00;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_status <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (r_pending) begin
            // Header was latched last cycle; decide start or reject
            r_pending <= 1'b0;
            if (w_hdr_ok) begin
              r_state  <= c_S_START;
              r_status <= 1'b1;
              r_busy   <= 1'b1;
              r_index  <= 3'd0;
            end else begin
              r_err       <= 1'b1;
              r_cmd_ready <= 1'b1;
            end
          end else if (CMD_VALID && r_cmd_ready) begin
            r_data      <= CMD_DATA;
            r_pending   <= 1'b1;
            r_cmd_ready <= 1'b0;
          end
        end
        c_S_START: begin
          r_state <= c_S_SETUP;
          r_rbyte <= w_sel_byte;
          r_index <= 3'd0;
        end
        c_S_SETUP: begin
          r_state <= c_S_HIGH;
          r_valid <= 1'b1;
          r_cnt   <= '0;
        end
        c_S_HIGH: begin
          if (r_cnt == c_HOLD_LAST) begin
            r_state <= c_S_LOW;
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_S_LOW: begin
          if (r_cnt == c_GAP_LAST) begin
            r_cnt <= '0;
            if (r_index == w_last_idx) begin
              r_state <= c_S_WAIT_READ;
            end else begin
              r_index <= r_index + 3'd1;
              r_rbyte <= w_sel_byte;
              r_state <= c_S_SETUP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_S_WAIT_READ: begin
          if ((FinishRead && FinishWrite) || w_wd_fire) begin
            r_state     <= c_S_IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end else if (FinishRead) begin
            r_state <= c_S_WAIT_DONE;
          end
        end
        c_S_WAIT_DONE: begin
          if (FinishWrite || w_wd_fire) begin
            r_state     <= c_S_IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= c_S_IDLE;
          r_busy      <= 1'b0;
          r_valid     <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign CMD_READY = r_cmd_ready;
  assign STATUS    = r_status;
  assign RByte     = r_rbyte;
  assign VALID     = r_valid;
  assign BUSY      = r_busy;
  assign ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_draw_cmd_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_cmd_sender
// Purpose  : Directed self-checking bench for draw_cmd_sender.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_cmd_sender;

  logic        ACLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic [55:0] CMD_DATA = 56'd0;
  logic        FinishRead = 1'b0;
  logic        FinishWrite = 1'b0;
  logic        CMD_READY, STATUS, VALID, BUSY, ERR, TIMEOUT;
  logic [7:0]  RByte;

  int checks = 0;
  int failures = 0;

  // Observations gathered by capture()
  int cap_status_cnt, cap_status_first, cap_pulses, cap_first_valid;
  int cap_ready_t, cap_unstable, cap_err_cnt, cap_err_first;
  int cap_timeout_cnt, cap_timeout_first, cap_busy_t1, cap_busy_cnt;
  int cap_hi[8];
  int cap_lo[8];
  logic [7:0] cap_byte[8];
  logic rs_valid, rs_status, rs_ready, rs_busy;
  logic [7:0] rs_rbyte;

  draw_cmd_sender #(
    .HOLD_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_DATA(CMD_DATA), .STATUS(STATUS), .RByte(RByte), .VALID(VALID),
    .FinishRead(FinishRead), .FinishWrite(FinishWrite), .BUSY(BUSY),
    .ERR(ERR), .TIMEOUT(TIMEOUT)
  );

  always #5 ACLK = ~ACLK;

  // Offers a command, then samples every cycle (t = edges since accept).
  // mode 0: FinishRead at t=7N+3, FinishWrite at t=7N+6; mode 1: both held
  // high throughout; mode 2: never asserted. hold_at>0 offers hold_data at
  // that t and leaves it offered; rst_at>0 pulses RESET at that t and stops.
  task automatic capture(input logic [55:0] data, input int n_exp, input int mode,
                         input int hold_at, input logic [55:0] hold_data, input int rst_at);
    int t;
    int cur_hi;
    int cur_lo;
    logic prev;
    cap_status_cnt = 0; cap_status_first = -1; cap_pulses = 0; cap_first_valid = -1;
    cap_ready_t = -1; cap_unstable = 0; cap_err_cnt = 0; cap_err_first = -1;
    cap_timeout_cnt = 0; cap_timeout_first = -1; cap_busy_t1 = -1; cap_busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin cap_hi[i] = 0; cap_lo[i] = 0; cap_byte[i] = 8'h00; end
    cur_hi = 0; cur_lo = 0; prev = 1'b0;
    if (mode == 1) begin FinishRead = 1'b1; FinishWrite = 1'b1; end
    CMD_DATA = data; CMD_VALID = 1'b1;
    @(posedge ACLK); #1;
    if (hold_at == 0) CMD_VALID = 1'b0;
    t = 0;
    while (t < 400) begin
      if (hold_at > 0 && t == hold_at) begin CMD_VALID = 1'b1; CMD_DATA = hold_data; end
      if (rst_at > 0 && t == rst_at) begin
        RESET = 1'b1; #1;
        rs_valid = VALID; rs_status = STATUS; rs_ready = CMD_READY;
        rs_busy = BUSY; rs_rbyte = RByte;
        @(posedge ACLK); #1;
        RESET = 1'b0;
        break;
      end
      if (STATUS) begin cap_status_cnt++; if (cap_status_first < 0) cap_status_first = t; end
      if (ERR) begin cap_err_cnt++; if (cap_err_first < 0) cap_err_first = t; end
      if (TIMEOUT) begin cap_timeout_cnt++; if (cap_timeout_first < 0) cap_timeout_first = t; end
      if (BUSY) cap_busy_cnt++;
      if (t == 1) cap_busy_t1 = int'(BUSY);
      if (VALID && !prev) begin
        if (cap_pulses == 0) cap_first_valid = t;
        else if (cap_pulses <= 8) cap_lo[cap_pulses-1] = cur_lo;
        if (cap_pulses < 8) cap_byte[cap_pulses] = RByte;
        cap_pulses++;
        cur_hi = 1;
      end else if (VALID) begin
        cur_hi++;
        if (cap_pulses <= 8 && RByte !== cap_byte[cap_pulses-1]) cap_unstable++;
      end else if (prev) begin
        if (cap_pulses <= 8) cap_hi[cap_pulses-1] = cur_hi;
        cur_lo = 1;
      end else begin
        cur_lo++;
      end
      prev = VALID;
      if (mode == 0 && t == 7*n_exp + 3) FinishRead = 1'b1;
      if (mode == 0 && t == 7*n_exp + 6) FinishWrite = 1'b1;
      if (t > 0 && CMD_READY) begin cap_ready_t = t; break; end
      @(posedge ACLK); #1;
      t++;
    end
    FinishRead = 1'b0; FinishWrite = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    checks++; if (CMD_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", CMD_READY); end
    checks++; if (STATUS !== 1'b0) begin failures++; $display("FAIL reset_status got=%b exp=0", STATUS); end
    checks++; if (RByte !== 8'h00) begin failures++; $display("FAIL reset_rbyte got=%h exp=00", RByte); end
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", VALID); end
    checks++; if ({BUSY, ERR, TIMEOUT} !== 3'b000) begin failures++; $display("FAIL reset_busy_err_to got=%b exp=000", {BUSY, ERR, TIMEOUT}); end
    RESET = 1'b0;
    @(posedge ACLK); #1;
    checks++; if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b%b exp=10", CMD_READY, BUSY); end
  endtask

  task automatic test_four_byte();
    logic [55:0] d;
    d = 56'h00_00_00_30_20_10_01;
    capture(d, 4, 0, 0, 56'd0, 0);
    checks++; if (cap_status_cnt != 1) begin failures++; $display("FAIL f4_status_len got=%0d exp=1", cap_status_cnt); end
    checks++; if (cap_status_first != 1) begin failures++; $display("FAIL f4_status_lat got=%0d exp=1", cap_status_first); end
    checks++; if (cap_busy_t1 != 1) begin failures++; $display("FAIL f4_busy got=%0d exp=1", cap_busy_t1); end
    checks++; if (cap_first_valid != 3) begin failures++; $display("FAIL f4_first_valid got=%0d exp=3", cap_first_valid); end
    checks++; if (cap_pulses != 4) begin failures++; $display("FAIL f4_pulses got=%0d exp=4", cap_pulses); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_byte[i] !== d[8*i +: 8]) begin failures++; $display("FAIL f4_byte%0d got=%h exp=%h", i, cap_byte[i], d[8*i +: 8]); end
      checks++; if (cap_hi[i] != 4) begin failures++; $display("FAIL f4_high%0d got=%0d exp=4", i, cap_hi[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (cap_lo[i] != 3) begin failures++; $display("FAIL f4_low%0d got=%0d exp=3", i, cap_lo[i]); end
    end
    checks++; if (cap_unstable != 0) begin failures++; $display("FAIL f4_rbyte_stable got=%0d exp=0", cap_unstable); end
    checks++; if (cap_ready_t != 35) begin failures++; $display("FAIL f4_ready_time got=%0d exp=35", cap_ready_t); end
    checks++; if (BUSY !== 1'b0 || cap_err_cnt != 0) begin failures++; $display("FAIL f4_end_idle got=%b/%0d exp=0/0", BUSY, cap_err_cnt); end
    checks++; if (cap_timeout_cnt != 0) begin failures++; $display("FAIL f4_no_timeout got=%0d exp=0", cap_timeout_cnt); end
  endtask

  task automatic test_six_byte_same_cycle_finish();
    logic [55:0] d;
    d = 56'hE5_D4_C3_B2_A1_02;
    capture(d, 6, 1, 0, 56'd0, 0);
    checks++; if (cap_pulses != 6) begin failures++; $display("FAIL f6_pulses got=%0d exp=6", cap_pulses); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_byte[i] !== d[8*i +: 8]) begin failures++; $display("FAIL f6_byte%0d got=%h exp=%h", i, cap_byte[i], d[8*i +: 8]); end
    end
    checks++; if (cap_ready_t != 45) begin failures++; $display("FAIL f6_ready_time got=%0d exp=45", cap_ready_t); end
    checks++; if (cap_status_cnt != 1) begin failures++; $display("FAIL f6_status_len got=%0d exp=1", cap_status_cnt); end
  endtask

  task automatic test_reject();
    logic [55:0] hdrs[2];
    hdrs[0] = 56'h66_55_44_33_22_11_03;
    hdrs[1] = 56'h66_55_44_33_22_11_00;
    for (int k = 0; k < 2; k++) begin
      capture(hdrs[k], 0, 2, 0, 56'd0, 0);
      checks++; if (cap_err_first != 1 || cap_err_cnt != 1) begin failures++; $display("FAIL rej%0d_err got=%0d/%0d exp=1/1", k, cap_err_first, cap_err_cnt); end
      checks++; if (cap_ready_t != 1) begin failures++; $display("FAIL rej%0d_ready got=%0d exp=1", k, cap_ready_t); end
      checks++; if (cap_status_cnt != 0 || cap_pulses != 0 || cap_busy_cnt != 0) begin failures++; $display("FAIL rej%0d_quiet got=%0d/%0d/%0d exp=0/0/0", k, cap_status_cnt, cap_pulses, cap_busy_cnt); end
      @(posedge ACLK); #1;
      checks++; if (ERR !== 1'b0 || BUSY !== 1'b0 || STATUS !== 1'b0) begin failures++; $display("FAIL rej%0d_after got=%b%b%b exp=000", k, ERR, BUSY, STATUS); end
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] d1;
    logic [55:0] d2;
    d1 = 56'h00_00_00_C3_B2_A1_01;
    d2 = 56'h00_00_00_00_00_5A_04;
    capture(d1, 4, 0, 17, d2, 0);
    checks++; if (cap_pulses != 4) begin failures++; $display("FAIL b2b_first_pulses got=%0d exp=4", cap_pulses); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_byte[i] !== d1[8*i +: 8]) begin failures++; $display("FAIL b2b_first_byte%0d got=%h exp=%h", i, cap_byte[i], d1[8*i +: 8]); end
    end
    checks++; if (cap_ready_t != 35 || cap_err_cnt != 0) begin failures++; $display("FAIL b2b_first_end got=%0d/%0d exp=35/0", cap_ready_t, cap_err_cnt); end
    capture(d2, 2, 0, 0, 56'd0, 0);
    checks++; if (cap_pulses != 2 || cap_status_first != 1) begin failures++; $display("FAIL b2b_second_pulses got=%0d/%0d exp=2/1", cap_pulses, cap_status_first); end
    checks++; if (cap_byte[0] !== 8'h04 || cap_byte[1] !== 8'h5A) begin failures++; $display("FAIL b2b_second_bytes got=%h%h exp=045a", cap_byte[0], cap_byte[1]); end
    checks++; if (cap_ready_t != 21) begin failures++; $display("FAIL b2b_second_ready got=%0d exp=21", cap_ready_t); end
  endtask

  task automatic test_reset_midframe();
    logic [55:0] d;
    d = 56'h00_00_00_33_22_11_01;
    capture(d, 4, 2, 0, 56'd0, 11);
    checks++; if (cap_pulses != 2) begin failures++; $display("FAIL rst_pulses_before got=%0d exp=2", cap_pulses); end
    checks++; if ({rs_valid, rs_status, rs_ready, rs_busy} !== 4'b0010) begin failures++; $display("FAIL rst_outputs got=%b exp=0010", {rs_valid, rs_status, rs_ready, rs_busy}); end
    checks++; if (rs_rbyte !== 8'h00) begin failures++; $display("FAIL rst_rbyte got=%h exp=00", rs_rbyte); end
    capture(d, 4, 0, 0, 56'd0, 0);
    checks++; if (cap_pulses != 4 || cap_byte[0] !== 8'h01 || cap_byte[1] !== 8'h11) begin failures++; $display("FAIL rst_resend got=%0d/%h/%h exp=4/01/11", cap_pulses, cap_byte[0], cap_byte[1]); end
    checks++; if (cap_ready_t != 35) begin failures++; $display("FAIL rst_resend_ready got=%0d exp=35", cap_ready_t); end
  endtask

`ifdef DRAW_CMD_TIMEOUT_EN
  task automatic test_timeout();
    capture(56'h00_00_00_00_00_77_04, 2, 2, 0, 56'd0, 0);
    checks++; if (cap_timeout_first != 32 || cap_timeout_cnt != 1) begin failures++; $display("FAIL to_pulse got=%0d/%0d exp=32/1", cap_timeout_first, cap_timeout_cnt); end
    checks++; if (cap_ready_t != 32) begin failures++; $display("FAIL to_ready got=%0d exp=32", cap_ready_t); end
    @(posedge ACLK); #1;
    checks++; if (TIMEOUT !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL to_after got=%b%b exp=00", TIMEOUT, BUSY); end
  endtask
`endif

  initial begin
    test_reset();
    test_four_byte();
    test_six_byte_same_cycle_finish();
    test_reject();
    test_back_to_back();
    test_reset_midframe();
`ifdef DRAW_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/draw_cmd_sender.md
Name: draw_cmd_sender

Overview:
- Transmit side of the render command byte link. Takes one parallel draw command (header plus up to 6 operand bytes) from the host-side controller.
- Serialises it as a STATUS start pulse followed by RByte/VALID level handshakes into the render unit's 7-entry command register file.
- After the last byte, waits for FinishRead and then FinishWrite before accepting the next command.

Parameters:
HOLD_CYCLES, 4, cycles VALID is held high per byte; legal range is ≥3 (receiver needs 3 cycles of stable RByte after VALID rises).
GAP_CYCLES, 2, cycles VALID is held low after each byte; legal range is ≥2.
TIMEOUT_CYCLES, 1024, watchdog limit while waiting for Finish flags (used only with DRAW_CMD_TIMEOUT_EN).

Ports:
ACLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
CMD_VALID  in  1  command offered.
CMD_READY  out  1  sender idle, able to accept a command.
CMD_DATA  in  56  byte k at [8k+7:8k]; byte0 is the header.
STATUS  out  1  one-cycle start pulse to the receiver.
RByte  out  8  command byte.
VALID  out  1  byte-valid level.
FinishRead  in  1  receiver has latched all bytes (level).
FinishWrite  in  1  draw complete (level).
BUSY  out  1  high in every state except IDLE.
ERR  out  1  one-cycle pulse when a header is rejected.
TIMEOUT  out  1  one-cycle watchdog pulse; tied 0 when the feature is compiled out.

Behaviour:
- Reset values: CMD_READY=1, STATUS=0, RByte=0, VALID=0, BUSY=0, ERR=0, TIMEOUT=0; state=IDLE; byte index=0; all counters=0.
- Byte count: N = 2*hdr[1:0]+2, so hdr[1:0]=0 gives 2 bytes, 1 gives 4, 2 gives 6.
- Rejected headers: hdr==0x00 or hdr[1:0]==3. On acceptance of such a header, ERR pulses the following cycle and the state stays IDLE.
- All outputs are registered.
- States:
  - IDLE: CMD_READY=1. On CMD_VALID&&CMD_READY, latch CMD_DATA and check the header. If valid, go to START.
  - START (1 cycle): STATUS=1, VALID=0, index=0 → SETUP.
  - SETUP (1 cycle): RByte=byte[index], VALID=0 → HIGH.
  - HIGH (HOLD_CYCLES cycles): VALID=1; RByte stable → LOW.
  - LOW (GAP_CYCLES cycles): VALID=0; RByte stable. Then, if index==N-1 → WAIT_READ; else index+1 → SETUP.
  - WAIT_READ: VALID=0. If FinishRead&&FinishWrite → IDLE; else if FinishRead → WAIT_DONE.
  - WAIT_DONE: on FinishWrite=1 → IDLE.
- Latency and timing:
  - Accept edge to STATUS high: 1 cycle.
  - STATUS to first VALID rise: 2 cycles.
  - Per-byte period: 1+HOLD_CYCLES+GAP_CYCLES cycles.
  - Total at default parameters: 2+7N cycles to reach WAIT_READ.
- Finish flags are sampled only in WAIT_READ and WAIT_DONE. Stale levels from the previous command are cleared by the receiver before then, and must be ignored in all other states.
- CMD_VALID while BUSY: ignored, no latch, CMD_READY=0.
- RESET asserted mid-operation (any state): immediate return to reset values; the partial frame is abandoned. The receiver must also be reset by the system.
- Counters saturate at their terminal value and reload on state entry; no wrap.

Optional Feature:
- Macro: DRAW_CMD_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter runs in WAIT_READ and WAIT_DONE and clears on entry to each.
  - On reaching TIMEOUT_CYCLES, TIMEOUT pulses 1 cycle and the state goes to IDLE.
  - If a Finish condition arrives in the same cycle as expiry, the Finish condition wins and TIMEOUT stays 0.
- Undefined: no counter is built, TIMEOUT is constant 0, and the wait states can hang indefinitely.

Test Plan:
- Header 0x01, bytes 0x01,0x10,0x20,0x30 → STATUS 1 cycle; 4 VALID pulses, each 4 cycles high and 2 low; RByte matches byte order; FinishRead then FinishWrite → IDLE, CMD_READY=1.
- Header 0x02, 6 bytes, FinishRead and FinishWrite asserted in the same cycle in WAIT_READ → 6 pulses, direct WAIT_READ→IDLE; 44 cycles from accept to WAIT_READ.
- Header 0x03 and header 0x00 → ERR=1 for 1 cycle, no STATUS, no VALID, BUSY stays 0.
- CMD_VALID held with a new command during HIGH of byte 2 → ignored; RByte sequence unchanged; new command accepted only after return to IDLE.
- RESET pulse during HIGH of byte 1 → VALID=0, STATUS=0, RByte=0, CMD_READY=1 on reset assertion; next command resends from byte 0.
- DRAW_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, FinishRead never asserted → TIMEOUT pulses 16 cycles after WAIT_READ entry, then IDLE.
